// File: rtl/seq_mant_mult_if.sv
// Request/result bundle for the sequential significand multiplier.
// The master drives operands and start; the slave returns the product and status.
interface seq_mant_mult_if #(
   parameter int MANT_W = 23
);
   localparam int SW = MANT_W + 1;
   localparam int PW = 2 * SW;

   logic              start;
   logic              a_hidden;
   logic [MANT_W-1:0] a_mant;
   logic              b_hidden;
   logic [MANT_W-1:0] b_mant;
   logic [PW-1:0]     prdt;
   logic              busy;
   logic              done;

   modport master (
      output start,
      output a_hidden,
      output a_mant,
      output b_hidden,
      output b_mant,
      input  prdt,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  a_hidden,
      input  a_mant,
      input  b_hidden,
      input  b_mant,
      output prdt,
      output busy,
      output done
   );
endinterface

// File: rtl/seq_mant_mult.sv
// Radix-2 shift-add significand multiplier, one multiplier bit per clock.
// Zero operands skip the iteration and report a zero product next cycle.
module seq_mant_mult #(
   parameter int MANT_W = 23
) (
   input logic        clk,
   input logic        rst_n,
   seq_mant_mult_if.slave bus
);
   localparam int SW = MANT_W + 1;
   localparam int PW = 2 * SW;
   localparam int CW = $clog2(SW);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t        state_q;
   state_t        state_d;

   logic [SW-1:0] sa_q;
   logic [SW-1:0] sb_q;
   logic [PW-1:0] acc_q;
   logic [PW-1:0] prdt_q;
   logic [CW-1:0] cnt_q;

   logic [SW-1:0] sa_in;
   logic [SW-1:0] sb_in;
   logic          in_zero;
   logic          accept;
   logic          last_iter;
   logic [PW-1:0] addend;
   logic [PW-1:0] acc_nxt;

   assign sa_in     = {bus.a_hidden, bus.a_mant};
   assign sb_in     = {bus.b_hidden, bus.b_mant};
   assign in_zero   = ~|sa_in || ~|sb_in;
   assign accept    = (state_q == IDLE) && bus.start;
   assign last_iter = (cnt_q == CW'(SW - 1));

   // Partial product for the multiplier bit selected by the counter.
   assign addend  = sb_q[cnt_q] ? ({{SW{1'b0}}, sa_q} << cnt_q) : '0;
   assign acc_nxt = acc_q + addend;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = in_zero ? DONE : CALC;
            end
         end
         CALC: begin
            if (last_iter) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa_q   <= '0;
         sb_q   <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         prdt_q <= '0;
      end else begin
         if (accept) begin
            sa_q  <= sa_in;
            sb_q  <= sb_in;
            acc_q <= '0;
            cnt_q <= '0;
            if (in_zero) begin
               prdt_q <= '0;
            end
         end else if (state_q == CALC) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q + 1'b1;
            if (last_iter) begin
               prdt_q <= acc_nxt;
            end
         end
      end
   end

   assign bus.prdt = prdt_q;
   assign bus.busy = (state_q != IDLE);
   assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_seq_mant_mult.sv
// Directed and random checks of seq_mant_mult at the default 23-bit mantissa.
// Expected products are hand constants or the bench's own SA*SB.
module tb_seq_mant_mult;
   localparam int MANT_W = 23;
   localparam int SW = MANT_W + 1;
   localparam int PW = 2 * SW;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;
   logic [PW-1:0] last_p;

   seq_mant_mult_if #(.MANT_W(MANT_W)) bus ();

   seq_mant_mult #(.MANT_W(MANT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic start_op(input logic [SW-1:0] sa, input logic [SW-1:0] sb);
      bus.start    = 1'b1;
      bus.a_hidden = sa[SW-1];
      bus.a_mant   = sa[MANT_W-1:0];
      bus.b_hidden = sb[SW-1];
      bus.b_mant   = sb[MANT_W-1:0];
   endtask

   // Accept edge, then count edges until done; zero ops finish at once,
   // full ops need SW more edges.
   task automatic wait_op(input string tag, input logic [PW-1:0] exp,
                          input bit zero, input bit hold,
                          input logic [SW-1:0] na, input logic [SW-1:0] nb);
      int edges;
      @(posedge clk);
      #1;
      if (!hold) bus.start = 1'b0;
      chk($sformatf("%s_acc_busy", tag), 64'(bus.busy), 64'd1);
      edges = 0;
      while (!bus.done && edges < 100) begin
         if (edges == 3 && hold) begin
            bus.a_hidden = na[SW-1];
            bus.a_mant   = na[MANT_W-1:0];
            bus.b_hidden = nb[SW-1];
            bus.b_mant   = nb[MANT_W-1:0];
         end
         if (edges == 5) begin
            chk($sformatf("%s_hold", tag), 64'(bus.prdt), 64'(last_p));
            chk($sformatf("%s_calc_busy", tag), 64'(bus.busy), 64'd1);
         end
         @(posedge clk);
         #1;
         edges++;
      end
      chk($sformatf("%s_lat", tag), 64'(edges), zero ? 64'd0 : 64'(SW));
      chk($sformatf("%s_prdt", tag), 64'(bus.prdt), 64'(exp));
      @(posedge clk);
      #1;
      chk($sformatf("%s_pulse", tag), 64'(bus.done), 64'd0);
      chk($sformatf("%s_idle", tag), 64'(bus.busy), 64'd0);
      last_p = exp;
   endtask

   initial begin
      logic [SW-1:0] sa;
      logic [SW-1:0] sb;
      logic [PW-1:0] e;
      int dcnt;
      n_chk  = 0;
      n_fail = 0;
      last_p = '0;
      rst_n  = 1'b0;
      bus.start    = 1'b0;
      bus.a_hidden = 1'b0;
      bus.a_mant   = '0;
      bus.b_hidden = 1'b0;
      bus.b_mant   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_prdt", 64'(bus.prdt), 64'd0);

      // Start already high at release: the first live edge must accept.
      start_op(24'h800000, 24'h800000);
      #3 rst_n = 1'b1;
      wait_op("one", 48'h400000000000, 1'b0, 1'b0, '0, '0);

      start_op(24'hC00000, 24'hC00000);
      wait_op("c_sq", 48'h900000000000, 1'b0, 1'b0, '0, '0);
      start_op(24'hFFFFFF, 24'hFFFFFF);
      wait_op("max", 48'hFFFFFE000001, 1'b0, 1'b0, '0, '0);
      start_op(24'hC00000, 24'h800000);
      wait_op("c_one", 48'h600000000000, 1'b0, 1'b0, '0, '0);
      start_op(24'h000001, 24'hFFFFFF);
      wait_op("subn", 48'h000000FFFFFF, 1'b0, 1'b0, '0, '0);
      start_op(24'h000000, 24'hC00000);
      wait_op("zero_a", 48'h0, 1'b1, 1'b0, '0, '0);
      start_op(24'hFFFFFF, 24'h000000);
      wait_op("zero_b", 48'h0, 1'b1, 1'b0, '0, '0);

      // Start held through CALC and DONE with operands changed mid-run.
      start_op(24'hC00000, 24'hC00000);
      wait_op("held1", 48'h900000000000, 1'b0, 1'b1,
              24'hA00000, 24'h900000);
      wait_op("held2", 48'h5A0000000000, 1'b0, 1'b0, '0, '0);

      // Reset ten cycles into CALC.
      start_op(24'hFFFFFF, 24'hFFFFFF);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(bus.busy), 64'd0);
      chk("arst_done", 64'(bus.done), 64'd0);
      chk("arst_prdt", 64'(bus.prdt), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      dcnt = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done) dcnt++;
      end
      chk("arst_no_done", 64'(dcnt), 64'd0);
      last_p = '0;
      start_op(24'hC00000, 24'hC00000);
      wait_op("post_rst", 48'h900000000000, 1'b0, 1'b0, '0, '0);

      for (int i = 0; i < 1000; i++) begin
         sa = 24'($urandom);
         sb = 24'($urandom);
         if (i % 37 == 0) sa = '0;
         if (i % 41 == 0) sb = '0;
         if (i % 5 == 0) sa[SW-1] = 1'b1;
         e = PW'(sa) * PW'(sb);
         start_op(sa, sb);
         wait_op($sformatf("rnd%0d", i), e, (sa == 0) || (sb == 0),
                 1'b0, '0, '0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/seq_mant_mult.md
SEQ_MANT_MULT -- requirements
Module: seq_mant_mult

Interface
REQ-001 SHALL have parameter: MANT_W, default 23, stored-mantissa width; significand width SW = MANT_W+1; product width PW = 2*SW.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request to begin a multiply; sampled on rising clk.
REQ-005 SHALL have port: a_hidden  input  1  hidden bit of operand A (1 normal, 0 zero/subnormal).
REQ-006 SHALL have port: a_mant  input  MANT_W  stored mantissa of operand A.
REQ-007 SHALL have port: b_hidden  input  1  hidden bit of operand B.
REQ-008 SHALL have port: b_mant  input  MANT_W  stored mantissa of operand B.
REQ-009 SHALL have port: prdt  output  PW  unsigned significand product, registered, feeds the downstream normalize stage.
REQ-010 SHALL have port: busy  output  1  high while a multiply is in progress.
REQ-011 SHALL have port: done  output  1  one-cycle pulse; prdt is valid from this cycle onward.

Function
REQ-012 SHALL form significands SA = {a_hidden,a_mant} and SB = {b_hidden,b_mant}, both SW bits, captured on the accepting edge; later input changes have no effect on the running operation.
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; reset state IDLE.
REQ-014 SHALL accept start only in IDLE; start in CALC or DONE ignored, no queuing.
REQ-015 IDLE + start + (SA==0 or SB==0) SHALL go to DONE next edge with prdt loaded to 0 (zero early-exit, done 1 cycle after accept).
REQ-016 IDLE + start + both non-zero SHALL go to CALC, clear accumulator and iteration counter.
REQ-017 CALC SHALL perform radix-2 shift-add, one multiplier bit per cycle, LSB first: if current bit of SB set, accumulator += SA shifted by counter value; counter increments.
REQ-018 CALC SHALL last exactly SW cycles (24 at default); on the edge completing iteration SW-1, state -> DONE and prdt <= final accumulator.
REQ-019 Full-latency case: done SHALL be high in the cycle following the SW-th edge after the accepting edge (24 cycles after accept at default).
REQ-020 DONE SHALL last exactly one cycle, then -> IDLE unconditionally.
REQ-021 busy SHALL be 1 in CALC and DONE, 0 in IDLE; done SHALL be 1 only in DONE.
REQ-022 prdt SHALL hold its value from DONE until the next DONE; not disturbed during a subsequent CALC.
REQ-023 Accumulator SHALL be PW bits wide; no overflow possible (max (2^SW-1)^2 < 2^PW).
REQ-024 start asserted in the same cycle done is high SHALL be ignored; back-to-back throughput is one operation per SW+2 cycles.

Reset
REQ-025 rst_n low SHALL immediately, without clk, force state IDLE, prdt=0, busy=0, done=0, accumulator and counter 0.
REQ-026 rst_n asserted mid-CALC SHALL abort the operation; no done pulse for it after release.
REQ-027 First start SHALL be accepted on the first rising clk with rst_n high.

Verification
REQ-028 SA=SB=0x800000 (hidden=1, mant=0) -> done 24 cycles after accept, prdt=48'h400000000000.
REQ-029 SA=SB=0xC00000 (1.5x1.5) -> prdt=48'h900000000000; SA=SB=0xFFFFFF -> prdt=48'hFFFFFE000001.
REQ-030 a_hidden=0, a_mant=0, any B -> done 1 cycle after accept, prdt=0, busy high exactly 1 cycle.
REQ-031 start held high continuously and operands changed during CALC -> result reflects captured operands only; next accept occurs in the IDLE cycle after done.
REQ-032 rst_n pulsed low 10 cycles into CALC -> busy, done, prdt 0 asynchronously; no done pulse until a new start completes.
REQ-033 Random 1000 operand pairs -> prdt equals SA*SB exactly, done pulse width 1, latency per REQ-015/REQ-019.
